udma_ptp_ts_gather: RTL and testbench

- TX-direction companion to the PTP timestamp uDMA RX channel.
- Collects 32-bit words that the uDMA TX channel fetches from L2 and packs every three of them into one 96-bit PTP timestamp.
- Drives each packed timestamp onto an AXI-stream output, e.g. for the PTP clock set/adjust port.
- Single clock domain (sys_clk_i). Any CDC to the PTP clock is done outside this block.

---
 rtl/udma_ptp_ts_pkg.sv | 17 +
 rtl/udma_ptp_ts_gather.sv | 145 ++++++++++++++
 tb/tb_udma_ptp_ts_gather.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/udma_ptp_ts_pkg.sv
// rtl/udma_ptp_ts_pkg.sv - shared widths, datasize code and word-index encoding for the PTP timestamp uDMA paths
package udma_ptp_ts_pkg;

   localparam int unsigned PTP_TS_WIDTH   = 96;
   localparam int unsigned PTP_WORD_WIDTH = 32;

   // uDMA datasize code for 32-bit words, common to the RX and TX channels
   localparam logic [1:0] UDMA_DATASIZE_32 = 2'b10;

   // Position of the next TX word inside the timestamp being assembled
   typedef enum logic [1:0] {
      IDX0 = 2'b00,
      IDX1 = 2'b01,
      IDX2 = 2'b10
   } ts_idx_e;

endpackage

// File: rtl/udma_ptp_ts_gather.sv
// rtl/udma_ptp_ts_gather.sv - packs three uDMA TX words into one 96-bit PTP timestamp on an AXI stream; optional ts_count_o via UDMA_PTP_TS_GATHER_CNT_EN
module udma_ptp_ts_gather
   import udma_ptp_ts_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = 32,
   parameter int unsigned NUM_WORDS  = 3,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                            sys_clk_i,
   input  logic                            rstn_i,
   input  logic                            clr_i,
   output logic [1:0]                      data_tx_datasize_o,
   input  logic [WORD_WIDTH-1:0]           data_tx_i,
   input  logic                            data_tx_valid_i,
   output logic                            data_tx_ready_o,
   output logic [WORD_WIDTH*NUM_WORDS-1:0] ptp_ts_axis_tdata,
   output logic                            ptp_ts_axis_tvalid,
   input  logic                            ptp_ts_axis_tready,
`ifdef UDMA_PTP_TS_GATHER_CNT_EN
   output logic [CNT_WIDTH-1:0]            ts_count_o,
`endif
   output logic                            partial_o
);

   // Upper two words of the timestamp are parked here until the third arrives
   localparam int unsigned ASM_WIDTH = PTP_TS_WIDTH - PTP_WORD_WIDTH;

   if (WORD_WIDTH != PTP_WORD_WIDTH) begin : g_bad_word_width
      $error("udma_ptp_ts_gather: WORD_WIDTH must be 32");
   end
   if (NUM_WORDS * WORD_WIDTH != PTP_TS_WIDTH) begin : g_bad_num_words
      $error("udma_ptp_ts_gather: NUM_WORDS must be 3");
   end
   if (CNT_WIDTH < 1) begin : g_bad_cnt_width
      $error("udma_ptp_ts_gather: CNT_WIDTH must be at least 1");
   end

   ts_idx_e                   idx_q, idx_d;
   logic [ASM_WIDTH-1:0]      asm_q, asm_d;
   logic [PTP_TS_WIDTH-1:0]   tdata_q, tdata_d;
   logic                      tvalid_q, tvalid_d;
   logic                      word_accept;
   logic                      last_accept;

   assign data_tx_datasize_o = UDMA_DATASIZE_32;
   assign ptp_ts_axis_tdata  = tdata_q;
   assign ptp_ts_axis_tvalid = tvalid_q;

   assign word_accept = data_tx_valid_i & data_tx_ready_o;
   assign last_accept = word_accept & (idx_q == IDX2);

   // Word-index state register
   always_ff @(posedge sys_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         idx_q <= IDX0;
      end else begin
         idx_q <= idx_d;
      end
   end

   // Word-index next state: advance on each accepted word, clear restarts, 2'b11 recovers to IDX0
   always_comb begin
      idx_d = idx_q;
      if (clr_i) begin
         idx_d = IDX0;
      end else begin
         case (idx_q)
            IDX0:    if (word_accept) idx_d = IDX1;
            IDX1:    if (word_accept) idx_d = IDX2;
            IDX2:    if (word_accept) idx_d = IDX0;
            default: idx_d = IDX0;
         endcase
      end
   end

   // FSM outputs: the third word is only refused while an undelivered timestamp blocks the output register
   always_comb begin
      data_tx_ready_o = ~clr_i &
                        ((idx_q != IDX2) | ~tvalid_q | ptp_ts_axis_tready);
      partial_o       = (idx_q != IDX0);
   end

   // Datapath next state: collect upper words, load the output on the third word, retire on handshake
   always_comb begin
      asm_d    = asm_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      if (tvalid_q & ptp_ts_axis_tready) begin
         tvalid_d = 1'b0;
      end
      if (clr_i) begin
         asm_d = '0;
      end else if (word_accept) begin
         case (idx_q)
            IDX0:    asm_d = {data_tx_i, {PTP_WORD_WIDTH{1'b0}}};
            IDX1:    asm_d = {asm_q[ASM_WIDTH-1:PTP_WORD_WIDTH], data_tx_i};
            IDX2: begin
               tdata_d  = {asm_q, data_tx_i};
               tvalid_d = 1'b1;
            end
            default: asm_d = asm_q;
         endcase
      end
   end

   // Assembly and output registers
   always_ff @(posedge sys_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         asm_q    <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
      end else begin
         asm_q    <= asm_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
      end
   end

`ifdef UDMA_PTP_TS_GATHER_CNT_EN
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   assign ts_count_o = cnt_q;

   // Completed-timestamp counter: wraps naturally, unaffected by clr_i
   always_comb begin
      cnt_d = cnt_q;
      if (last_accept) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register
   always_ff @(posedge sys_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   logic unused_last_accept;
   assign unused_last_accept = last_accept;
`endif

endmodule

// File: tb/tb_udma_ptp_ts_gather.sv
// tb/tb_udma_ptp_ts_gather.sv - directed self-checking bench for udma_ptp_ts_gather
module tb_udma_ptp_ts_gather;

   logic        clk;
   logic        rstn;
   logic        clr;
   logic [1:0]  datasize;
   logic [31:0] data;
   logic        valid;
   logic        ready;
   logic [95:0] tdata;
   logic        tvalid;
   logic        tready;
   logic        partial;
`ifdef UDMA_PTP_TS_GATHER_CNT_EN
   logic [3:0]  ts_count;
`endif

   int checks = 0;
   int errors = 0;

`ifdef UDMA_PTP_TS_GATHER_CNT_EN
   udma_ptp_ts_gather #(.CNT_WIDTH(4)) dut (
`else
   udma_ptp_ts_gather dut (
`endif
      .sys_clk_i          (clk),
      .rstn_i             (rstn),
      .clr_i              (clr),
      .data_tx_datasize_o (datasize),
      .data_tx_i          (data),
      .data_tx_valid_i    (valid),
      .data_tx_ready_o    (ready),
      .ptp_ts_axis_tdata  (tdata),
      .ptp_ts_axis_tvalid (tvalid),
      .ptp_ts_axis_tready (tready),
`ifdef UDMA_PTP_TS_GATHER_CNT_EN
      .ts_count_o         (ts_count),
`endif
      .partial_o          (partial)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] w);
      data  = w;
      valid = 1'b1;
      tick();
      valid = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      #3;
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", tvalid); end
      checks++; if (tdata !== 96'h0) begin errors++; $display("FAIL reset_tdata: got %h expected 0", tdata); end
      checks++; if (partial !== 1'b0) begin errors++; $display("FAIL reset_partial: got %b expected 0", partial); end
      checks++; if (datasize !== 2'b10) begin errors++; $display("FAIL datasize: got %b expected 10", datasize); end
`ifdef UDMA_PTP_TS_GATHER_CNT_EN
      checks++; if (ts_count !== 4'h0) begin errors++; $display("FAIL reset_count: got %h expected 0", ts_count); end
`endif
      tick();
      rstn = 1'b1;
      #1;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
   endtask

   task automatic test_back_to_back();
      tready = 1'b1;
      data = 32'h11111111; valid = 1'b1;
      #1;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_w1: got %b expected 1", ready); end
      tick();
      data = 32'h22222222;
      checks++; if (partial !== 1'b1) begin errors++; $display("FAIL b2b_partial_w1: got %b expected 1", partial); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_w2: got %b expected 1", ready); end
      tick();
      data = 32'h33333333;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_w3: got %b expected 1", ready); end
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL b2b_tvalid_early: got %b expected 0", tvalid); end
      tick();
      valid = 1'b0;
      checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL b2b_tvalid: got %b expected 1", tvalid); end
      checks++; if (tdata !== 96'h111111112222222233333333) begin errors++; $display("FAIL b2b_tdata: got %h expected 111111112222222233333333", tdata); end
      checks++; if (partial !== 1'b0) begin errors++; $display("FAIL b2b_partial_done: got %b expected 0", partial); end
      tick();
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL b2b_tvalid_retire: got %b expected 0", tvalid); end
   endtask

   task automatic test_backpressure();
      tready = 1'b0;
      push(32'hA0000001);
      push(32'hA0000002);
      push(32'hA0000003);
      checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL bp_tvalid_a: got %b expected 1", tvalid); end
      checks++; if (tdata !== 96'hA0000001A0000002A0000003) begin errors++; $display("FAIL bp_tdata_a: got %h expected A0000001A0000002A0000003", tdata); end
      push(32'hB0000001);
      push(32'hB0000002);
      data = 32'hB0000003; valid = 1'b1;
      #1;
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL bp_ready_stall: got %b expected 0", ready); end
      tick();
      checks++; if (tdata !== 96'hA0000001A0000002A0000003) begin errors++; $display("FAIL bp_tdata_hold: got %h expected A0000001A0000002A0000003", tdata); end
      checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL bp_tvalid_hold: got %b expected 1", tvalid); end
      checks++; if (partial !== 1'b1) begin errors++; $display("FAIL bp_partial_hold: got %b expected 1", partial); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL bp_ready_hold: got %b expected 0", ready); end
      tready = 1'b1;
      #1;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL bp_ready_release: got %b expected 1", ready); end
      tick();
      valid = 1'b0;
      checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL bp_tvalid_b: got %b expected 1", tvalid); end
      checks++; if (tdata !== 96'hB0000001B0000002B0000003) begin errors++; $display("FAIL bp_tdata_b: got %h expected B0000001B0000002B0000003", tdata); end
      tick();
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL bp_tvalid_retire: got %b expected 0", tvalid); end
   endtask

   task automatic test_gapped();
      logic [31:0] g [3];
      g[0] = 32'hC0FFEE01; g[1] = 32'h12345678; g[2] = 32'h9ABCDEF0;
      tready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push(g[i]);
         if (i == 2) begin
            checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL gap_tvalid: got %b expected 1", tvalid); end
            checks++; if (tdata !== 96'hC0FFEE01123456789ABCDEF0) begin errors++; $display("FAIL gap_tdata: got %h expected C0FFEE01123456789ABCDEF0", tdata); end
         end
         checks++; if (partial !== (i < 2)) begin errors++; $display("FAIL gap_partial_w%0d: got %b expected %b", i, partial, (i < 2)); end
         repeat (3) tick();
         checks++; if (partial !== (i < 2)) begin errors++; $display("FAIL gap_partial_idle%0d: got %b expected %b", i, partial, (i < 2)); end
      end
   endtask

   task automatic test_clear();
      tready = 1'b0;
      push(32'h0C0C0001);
      push(32'h0C0C0002);
      push(32'h0C0C0003);
      push(32'hAAAA0001);
      push(32'hAAAA0002);
      data = 32'hDEADBEEF; valid = 1'b1; clr = 1'b1;
      #1;
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL clr_ready: got %b expected 0", ready); end
      tick();
      clr = 1'b0; valid = 1'b0;
      checks++; if (partial !== 1'b0) begin errors++; $display("FAIL clr_partial: got %b expected 0", partial); end
      checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL clr_pending_tvalid: got %b expected 1", tvalid); end
      checks++; if (tdata !== 96'h0C0C00010C0C00020C0C0003) begin errors++; $display("FAIL clr_pending_tdata: got %h expected 0C0C00010C0C00020C0C0003", tdata); end
      tready = 1'b1;
      tick();
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL clr_pending_retire: got %b expected 0", tvalid); end
      push(32'h1);
      push(32'h2);
      push(32'h3);
      checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL clr_new_tvalid: got %b expected 1", tvalid); end
      checks++; if (tdata !== 96'h000000010000000200000003) begin errors++; $display("FAIL clr_new_tdata: got %h expected 000000010000000200000003", tdata); end
      tick();
   endtask

   task automatic test_async_reset();
      tready = 1'b0;
      push(32'h5A5A0001);
      push(32'h5A5A0002);
      push(32'h5A5A0003);
      push(32'h5A5A0004);
      checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL ares_pre_tvalid: got %b expected 1", tvalid); end
      checks++; if (partial !== 1'b1) begin errors++; $display("FAIL ares_pre_partial: got %b expected 1", partial); end
      #2;
      rstn = 1'b0;
      #1;
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL ares_tvalid: got %b expected 0", tvalid); end
      checks++; if (tdata !== 96'h0) begin errors++; $display("FAIL ares_tdata: got %h expected 0", tdata); end
      checks++; if (partial !== 1'b0) begin errors++; $display("FAIL ares_partial: got %b expected 0", partial); end
`ifdef UDMA_PTP_TS_GATHER_CNT_EN
      checks++; if (ts_count !== 4'h0) begin errors++; $display("FAIL ares_count: got %h expected 0", ts_count); end
`endif
      tick();
      rstn = 1'b1;
      tready = 1'b1;
      tick();
   endtask

`ifdef UDMA_PTP_TS_GATHER_CNT_EN
   task automatic test_count();
      tready = 1'b1;
      for (int t = 0; t < 17; t++) begin
         push(32'h100 + t);
         push(32'h200 + t);
         push(32'h300 + t);
         if (t % 4 == 0) begin
            clr = 1'b1;
            tick();
            clr = 1'b0;
         end
         if (t == 15) begin
            checks++; if (ts_count !== 4'h0) begin errors++; $display("FAIL cnt_wrap16: got %h expected 0", ts_count); end
         end
      end
      checks++; if (ts_count !== 4'h1) begin errors++; $display("FAIL cnt_17: got %h expected 1", ts_count); end
      push(32'hF1);
      push(32'hF2);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++; if (ts_count !== 4'h1) begin errors++; $display("FAIL cnt_clr_partial: got %h expected 1", ts_count); end
   endtask
`endif

   initial begin
      rstn = 1'b0; clr = 1'b0; data = '0; valid = 1'b0; tready = 1'b0;
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_gapped();
      test_clear();
      test_async_reset();
`ifdef UDMA_PTP_TS_GATHER_CNT_EN
      test_count();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
